// File: rtl/turn_sig_pkg.sv
// Shared types and default constants for the turn-signal input conditioner.
package turn_sig_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    ARM_HI,
    STABLE_HI,
    ARM_LO
  } db_state_t;

  localparam int DB_CYCLES_DEF = 16;
  localparam int TICK_DIV_DEF  = 8;

endpackage

// File: rtl/switch_debounce.sv
// One turn-switch channel: two-flop synchronizer, debounce FSM with stability
// counter, registered level and a one-cycle rise pulse on a 0->1 commit.
module switch_debounce
  import turn_sig_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_raw,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_commit,
  output db_state_t o_state
);

  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic            r_s1;
  logic            r_s2;
  db_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_level;
  logic            r_rise;
  logic            w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);

  // Combinational: high on the edge where the level is about to flip.
  assign o_commit = w_at_max &&
                    (((r_state == ARM_HI) && r_s2) ||
                     ((r_state == ARM_LO) && !r_s2));

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (r_s2) begin
            r_state <= ARM_HI;
            r_cnt   <= CW'(1);
          end
        end
        ARM_HI: begin
          if (!r_s2) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (w_at_max) begin
            r_state <= STABLE_HI;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!r_s2) begin
            r_state <= ARM_LO;
            r_cnt   <= CW'(1);
          end
        end
        ARM_LO: begin
          if (r_s2) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (w_at_max) begin
            // Falling commits never pulse.
            r_state <= STABLE_LO;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/turn_input_conditioner.sv
// Turn-switch front end: two debounced channels plus a step strobe whose
// phase restarts whenever the debounced switch pair changes.
module turn_input_conditioner
  import turn_sig_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  output logic left,
  output logic right,
  output logic left_rise,
  output logic right_rise,
  output logic tick
);

  localparam int            DW      = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  logic          w_left_commit;
  logic          w_right_commit;
  logic          w_change;
  db_state_t     w_left_state;
  db_state_t     w_right_state;
  logic [DW-1:0] r_div;
  logic          r_tick;

  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_left (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_raw    (left_raw),
    .o_level  (left),
    .o_rise   (left_rise),
    .o_commit (w_left_commit),
    .o_state  (w_left_state)
  );

  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_right (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_raw    (right_raw),
    .o_level  (right),
    .o_rise   (right_rise),
    .o_commit (w_right_commit),
    .o_state  (w_right_state)
  );

  assign w_change = w_left_commit | w_right_commit;
  assign tick     = r_tick;

  // A pattern change outranks a wrap so every new pattern gets a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (w_change) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == DIV_MAX) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + DW'(1);
      r_tick <= 1'b0;
    end
  end

  // Committed level must agree with the debounce state on every edge.
  a_left_level : assert property (@(posedge clk) disable iff (!reset)
    left == ((w_left_state == STABLE_HI) || (w_left_state == ARM_LO)));
  a_right_level : assert property (@(posedge clk) disable iff (!reset)
    right == ((w_right_state == STABLE_HI) || (w_right_state == ARM_LO)));

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Bench for turn_input_conditioner: window-based reference model feeding a
// per-cycle expected queue, plus scenario tasks with inline spot checks.
module tb_turn_input_conditioner;

  localparam int DB  = 4;
  localparam int TD  = 3;
  localparam int TD8 = 8;
  localparam int W   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic left, right, left_rise, right_rise, tick;
  logic t8_left, t8_right, t8_left_rise, t8_right_rise, t8_tick;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  logic          m_s1[2];
  logic          m_s2[2];
  logic          m_lvl[2];
  logic [DB-1:0] m_hist[2];
  int            m_nh[2];
  int            m_since;
  int            m_since8;

  always #5 clk = ~clk;

  turn_input_conditioner #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_raw   (left_raw),
    .right_raw  (right_raw),
    .left       (left),
    .right      (right),
    .left_rise  (left_rise),
    .right_rise (right_rise),
    .tick       (tick)
  );

  turn_input_conditioner #(.DB_CYCLES(DB), .TICK_DIV(TD8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .left_raw   (1'b0),
    .right_raw  (1'b0),
    .left       (t8_left),
    .right      (t8_right),
    .left_rise  (t8_left_rise),
    .right_rise (t8_right_rise),
    .tick       (t8_tick)
  );

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c]   = 1'b0;
      m_s2[c]   = 1'b0;
      m_lvl[c]  = 1'b0;
      m_hist[c] = '0;
      m_nh[c]   = 0;
    end
    m_since  = 0;
    m_since8 = 0;
  endfunction

  // A level flips when the last DB synchronized samples all disagree with it.
  function automatic void model_edge();
    logic seen;
    logic any_commit;
    logic rise[2];
    logic t, t8;
    any_commit = 1'b0;
    for (int c = 0; c < 2; c++) begin
      seen      = m_s2[c];
      m_s2[c]   = m_s1[c];
      m_s1[c]   = (c == 0) ? left_raw : right_raw;
      m_hist[c] = {m_hist[c][DB-2:0], seen};
      if (m_nh[c] < DB) m_nh[c]++;
      rise[c] = 1'b0;
      if (m_nh[c] == DB && m_hist[c] == {DB{~m_lvl[c]}}) begin
        m_lvl[c]   = ~m_lvl[c];
        any_commit = 1'b1;
        rise[c]    = m_lvl[c];
      end
    end
    if (any_commit) begin
      m_since = 0;
      t = 1'b0;
    end else begin
      m_since++;
      t = ((m_since % TD) == 0);
    end
    m_since8++;
    t8 = ((m_since8 % TD8) == 0);
    exp_q.push_back({m_lvl[0], m_lvl[1], rise[0], rise[1], t, t8});
  endfunction

  // Scoreboard: one expected entry per modelled edge.
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        obs_v = {left, right, left_rise, right_rise, tick, t8_tick};
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL scoreboard t=%0t got %b exp %b (l r lr rr tick tick8)",
                   $time, obs_v, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic l, input logic r);
    left_raw  = l;
    right_raw = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    left_raw  = 1'b1;
    right_raw = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({left, right, left_rise, right_rise, tick} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b exp 00000", {left, right, left_rise, right_rise, tick});
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({left, right, tick, t8_tick} !== 4'b0) begin
      errors++;
      $display("FAIL reset_held got %b exp 0000", {left, right, tick, t8_tick});
    end
    left_raw  = 1'b0;
    right_raw = 1'b0;
    release_reset();
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0);
      if (k == 5) begin
        checks++;
        if (left !== 1'b0) begin errors++; $display("FAIL press_early k=%0d got %b exp 0", k, left); end
      end
      if (k == 6) begin
        checks++;
        if ({left, left_rise} !== 2'b11) begin
          errors++; $display("FAIL press_commit k=%0d got %b exp 11", k, {left, left_rise});
        end
      end
      if (k == 7) begin
        checks++;
        if ({left, left_rise, tick} !== 3'b100) begin
          errors++; $display("FAIL press_after k=%0d got %b exp 100", k, {left, left_rise, tick});
        end
      end
      if (k == 8) begin
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL press_tick8 got %b exp 0", tick); end
      end
      if (k == 9) begin
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL press_tick9 got %b exp 1", tick); end
      end
    end
  endtask

  task automatic test_release();
    int rises;
    rises = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0);
      if (left_rise) rises++;
      if (k == 5) begin
        checks++;
        if (left !== 1'b1) begin errors++; $display("FAIL release_early got %b exp 1", left); end
      end
      if (k == 6) begin
        checks++;
        if (left !== 1'b0) begin errors++; $display("FAIL release_commit got %b exp 0", left); end
      end
      if (k == 7 || k == 8) begin
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL release_notick k=%0d got %b exp 0", k, tick); end
      end
      if (k == 9) begin
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL release_tick got %b exp 1", tick); end
      end
    end
    checks++;
    if (rises !== 0) begin errors++; $display("FAIL release_rises got %0d exp 0", rises); end
  endtask

  task automatic test_bounce();
    logic pat [14];
    int rises;
    int early_high;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rises = 0;
    early_high = 0;
    for (int k = 1; k <= 14; k++) begin
      step(pat[k-1], 1'b0);
      if (left_rise) rises++;
      if (k <= 10 && left) early_high++;
      if (k == 11) begin
        checks++;
        if ({left, left_rise} !== 2'b11) begin
          errors++; $display("FAIL bounce_commit got %b exp 11", {left, left_rise});
        end
      end
    end
    checks++;
    if (early_high !== 0) begin errors++; $display("FAIL bounce_early got %0d exp 0", early_high); end
    checks++;
    if (rises !== 1) begin errors++; $display("FAIL bounce_rises got %0d exp 1", rises); end
  endtask

  task automatic test_hazard();
    repeat (8) step(1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      if (k == 5) begin
        checks++;
        if ({left, right} !== 2'b00) begin errors++; $display("FAIL hazard_early got %b exp 00", {left, right}); end
      end
      if (k == 6) begin
        checks++;
        if ({left, right, left_rise, right_rise} !== 4'b1111) begin
          errors++; $display("FAIL hazard_commit got %b exp 1111", {left, right, left_rise, right_rise});
        end
      end
      if (k == 7) begin
        checks++;
        if ({left, right, left_rise, right_rise} !== 4'b1100) begin
          errors++; $display("FAIL hazard_after got %b exp 1100", {left, right, left_rise, right_rise});
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    repeat (8) step(1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    repeat (DB - 1) step(1'b1, 1'b1);
    checks++;
    if (dut.u_right.r_cnt !== 2'd1) begin
      errors++; $display("FAIL midcount_cnt got %0d exp 1", dut.u_right.r_cnt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({left, right, left_rise, right_rise, tick, t8_tick} !== 6'b0) begin
      errors++;
      $display("FAIL midcount_async got %b exp 000000", {left, right, left_rise, right_rise, tick, t8_tick});
    end
    checks++;
    if ({dut.u_left.r_cnt, dut.u_right.r_cnt, dut.r_div} !== 6'b0) begin
      errors++;
      $display("FAIL midcount_counters got %b exp 000000", {dut.u_left.r_cnt, dut.u_right.r_cnt, dut.r_div});
    end
    repeat (2) @(posedge clk);
    release_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      if (k == 2 + DB - 1) begin
        checks++;
        if ({left, right} !== 2'b00) begin errors++; $display("FAIL midcount_early got %b exp 00", {left, right}); end
      end
      if (k == 2 + DB) begin
        checks++;
        if ({right, right_rise} !== 2'b11) begin
          errors++; $display("FAIL midcount_commit got %b exp 11", {right, right_rise});
        end
      end
    end
  endtask

  task automatic test_tick_cadence();
    int ticks;
    int doubles;
    int stray;
    logic prev;
    @(negedge clk);
    reset = 1'b0;
    left_raw  = 1'b0;
    right_raw = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    ticks = 0;
    doubles = 0;
    stray = 0;
    prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b0);
      if (t8_tick) ticks++;
      if (t8_tick && prev) doubles++;
      if (t8_left | t8_right | t8_left_rise | t8_right_rise) stray++;
      prev = t8_tick;
      if (k == 8) begin
        checks++;
        if (t8_tick !== 1'b1) begin errors++; $display("FAIL cadence_first got %b exp 1", t8_tick); end
      end
    end
    checks++;
    if (ticks !== 5) begin errors++; $display("FAIL cadence_count got %0d exp 5", ticks); end
    checks++;
    if (doubles !== 0) begin errors++; $display("FAIL cadence_double got %0d exp 0", doubles); end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL cadence_idle_outputs got %0d exp 0", stray); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_hazard();
    test_reset_mid_count();
    test_tick_cadence();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
